spi_master_txp: RTL and testbench

//  Parametrised SPI master transmitter. Generalises the fixed mode-2, 8-bit TX master to:
//   - any data width and bit order
//   - all four CPOL/CPHA modes
//   - explicit CS setup/hold/gap timing and a done pulse

---
 rtl/spi_master_txp.sv | 156 +++++++++++++++
 tb/tb_spi_master_txp.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_txp.sv
// spi_master_txp: parametrised SPI master transmitter (any width, bit order, CPOL/CPHA mode).
// Define SPI_MISO_RX_EN to build the MISO capture path for full-duplex frames.
module spi_master_txp #(
  parameter int REF_CLK   = 50_000_000,
  parameter int SPI_SCLK  = 1_000_000,
  parameter int DATA_W    = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic              In_clk,
  input  logic              In_rst_n,
  input  logic              In_tx_req,
  input  logic [DATA_W-1:0] In_tx_data,
  input  logic              In_spi_miso,
  output logic              Out_tx_busy,
  output logic              Out_tx_done,
  output logic [DATA_W-1:0] Out_rx_data,
  output logic              Out_rx_valid,
  output logic              Out_spi_cs_n,
  output logic              Out_spi_sclk,
  output logic              Out_spi_mosi
);
  // state   | meaning
  // S_IDLE  | cs_n high, waiting for In_tx_req
  // S_SETUP | cs_n low, sclk at idle level for HALF cycles
  // S_SHIFT | 2*DATA_W sclk edges, one per half period
  // S_HOLD  | cs_n low after the last edge for HALF cycles
  // S_GAP   | cs_n high; together with IDLE gives HALF cycles of CS-high
  localparam int HALF = REF_CLK / (2 * SPI_SCLK);
  localparam int HCW  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int ECW  = $clog2(2 * DATA_W + 1);
  localparam logic [HCW-1:0] HALF_LD   = HCW'(HALF - 1);
  localparam logic [HCW-1:0] GAP_LD    = HCW'((HALF > 1) ? HALF - 2 : 0);
  localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_W - 1);
  localparam logic           IDLE_LVL  = 1'(CPOL);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t            state;
  logic [HCW-1:0]    half_cnt;
  logic [ECW-1:0]    edge_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] tx_ord;
  logic              cs_n, sclk, mosi, busy, done;
  logic              leading;

  // Shift registers always run MSB-first; LSB_FIRST is handled by reversing words.
  function automatic logic [DATA_W-1:0] order(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    if (LSB_FIRST != 0)
      for (int b = 0; b < DATA_W; b++) r[b] = d[DATA_W-1-b];
    return r;
  endfunction

  assign tx_ord  = order(In_tx_data);
  assign leading = ~edge_cnt[0];

`ifdef SPI_MISO_RX_EN
  logic [DATA_W-1:0] rx_sr, rx_data;
  logic              rx_valid;
  assign Out_rx_data  = rx_data;
  assign Out_rx_valid = rx_valid;
`else
  logic unused_miso;
  assign unused_miso  = In_spi_miso;
  assign Out_rx_data  = '0;
  assign Out_rx_valid = 1'b0;
`endif

  always_ff @(posedge In_clk or negedge In_rst_n) begin
    if (!In_rst_n) begin
      state    <= S_IDLE;
      half_cnt <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      cs_n     <= 1'b1;
      sclk     <= IDLE_LVL;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SPI_MISO_RX_EN
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SPI_MISO_RX_EN
      rx_valid <= 1'b0;
`endif
      case (state)
        S_IDLE: if (In_tx_req) begin
          state    <= S_SETUP;
          half_cnt <= HALF_LD;
          edge_cnt <= '0;
          cs_n     <= 1'b0;
          busy     <= 1'b1;
          if (CPHA == 0) begin
            tx_sr <= tx_ord << 1;
            mosi  <= tx_ord[DATA_W-1];
          end else begin
            tx_sr <= tx_ord;
            mosi  <= 1'b0;
          end
        end
        S_SETUP: if (half_cnt == '0) begin
          state    <= S_SHIFT;
          half_cnt <= HALF_LD;
        end else half_cnt <= half_cnt - 1'b1;
        S_SHIFT: if (half_cnt == '0) begin
          half_cnt <= HALF_LD;
          sclk     <= ~sclk;
          edge_cnt <= edge_cnt + 1'b1;
          // CPHA=0 preloads bit 0, so it skips the shift on the final trailing edge
          if ((CPHA == 0) ? (!leading && edge_cnt != LAST_EDGE) : leading) begin
            mosi  <= tx_sr[DATA_W-1];
            tx_sr <= tx_sr << 1;
          end
`ifdef SPI_MISO_RX_EN
          if (leading == (CPHA == 0)) rx_sr <= (rx_sr << 1) | DATA_W'(In_spi_miso);
`endif
          if (edge_cnt == LAST_EDGE) state <= S_HOLD;
        end else half_cnt <= half_cnt - 1'b1;
        S_HOLD: if (half_cnt == '0) begin
          cs_n <= 1'b1;
          done <= 1'b1;
          mosi <= 1'b0;
`ifdef SPI_MISO_RX_EN
          rx_data  <= order(rx_sr);
          rx_valid <= 1'b1;
`endif
          if (HALF > 1) begin
            state    <= S_GAP;
            half_cnt <= GAP_LD;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end else half_cnt <= half_cnt - 1'b1;
        S_GAP: if (half_cnt == '0) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else half_cnt <= half_cnt - 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Out_tx_busy  = busy;
  assign Out_tx_done  = done;
  assign Out_spi_cs_n = cs_n;
  assign Out_spi_sclk = sclk;
  assign Out_spi_mosi = mosi;
endmodule

// File: tb/tb_spi_master_txp.sv
// Bench for spi_master_txp: four instances covering all CPOL/CPHA modes, widths and bit orders,
// each with MISO looped back to MOSI so the optional receive path can be checked too.
`timescale 1ns/1ps
module tb_spi_master_txp;
  localparam int P_DW   [4] = '{8, 8, 16, 8};
  localparam int P_HALF [4] = '{25, 5, 3, 2};
  localparam int P_CPOL [4] = '{0, 1, 0, 1};
  localparam int P_CPHA [4] = '{0, 1, 1, 0};
  localparam int P_LSB  [4] = '{0, 1, 0, 1};
`ifdef SPI_MISO_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] txd [4];
  wire  [3:0]  cs_n, sclk, mosi, busy, done, rxv;
  wire  [7:0]  rx0, rx1, rx3;
  wire  [15:0] rx2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          edges;
    int          cs_low;
    int          n_done;
    bit          done_at_rise;
    bit          accept_ok;
    bit          pre_mosi_bad;
    bit          timeout;
    logic        first_mosi;
    logic        mosi_end;
    logic        sclk_end;
    logic [31:0] rx;
    logic        rxv_at_rise;
    int          rxv_stray;
  } frame_t;

  spi_master_txp u_dut0 (
    .In_clk(clk), .In_rst_n(rst_n), .In_tx_req(req[0]), .In_tx_data(txd[0][7:0]),
    .In_spi_miso(mosi[0]), .Out_tx_busy(busy[0]), .Out_tx_done(done[0]), .Out_rx_data(rx0),
    .Out_rx_valid(rxv[0]), .Out_spi_cs_n(cs_n[0]), .Out_spi_sclk(sclk[0]), .Out_spi_mosi(mosi[0]));

  spi_master_txp #(.REF_CLK(10_000_000), .SPI_SCLK(1_000_000), .DATA_W(8),
                   .CPOL(1), .CPHA(1), .LSB_FIRST(1)) u_dut1 (
    .In_clk(clk), .In_rst_n(rst_n), .In_tx_req(req[1]), .In_tx_data(txd[1][7:0]),
    .In_spi_miso(mosi[1]), .Out_tx_busy(busy[1]), .Out_tx_done(done[1]), .Out_rx_data(rx1),
    .Out_rx_valid(rxv[1]), .Out_spi_cs_n(cs_n[1]), .Out_spi_sclk(sclk[1]), .Out_spi_mosi(mosi[1]));

  spi_master_txp #(.REF_CLK(6_000_000), .SPI_SCLK(1_000_000), .DATA_W(16),
                   .CPOL(0), .CPHA(1), .LSB_FIRST(0)) u_dut2 (
    .In_clk(clk), .In_rst_n(rst_n), .In_tx_req(req[2]), .In_tx_data(txd[2][15:0]),
    .In_spi_miso(mosi[2]), .Out_tx_busy(busy[2]), .Out_tx_done(done[2]), .Out_rx_data(rx2),
    .Out_rx_valid(rxv[2]), .Out_spi_cs_n(cs_n[2]), .Out_spi_sclk(sclk[2]), .Out_spi_mosi(mosi[2]));

  spi_master_txp #(.REF_CLK(4_000_000), .SPI_SCLK(1_000_000), .DATA_W(8),
                   .CPOL(1), .CPHA(0), .LSB_FIRST(1)) u_dut3 (
    .In_clk(clk), .In_rst_n(rst_n), .In_tx_req(req[3]), .In_tx_data(txd[3][7:0]),
    .In_spi_miso(mosi[3]), .Out_tx_busy(busy[3]), .Out_tx_done(done[3]), .Out_rx_data(rx3),
    .Out_rx_valid(rxv[3]), .Out_spi_cs_n(cs_n[3]), .Out_spi_sclk(sclk[3]), .Out_spi_mosi(mosi[3]));

  function automatic logic [31:0] get_rx(input int i);
    case (i)
      0:       return {24'h0, rx0};
      1:       return {24'h0, rx1};
      2:       return {16'h0, rx2};
      default: return {24'h0, rx3};
    endcase
  endfunction

  // Reference: bit j of the vector is the j-th bit that should appear on the wire.
  function automatic logic [31:0] model_bits(input int i, input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < P_DW[i]; j++) r[j] = (P_LSB[i] != 0) ? d[j] : d[P_DW[i]-1-j];
    return r;
  endfunction

  function automatic logic [31:0] rand_data(input int i);
    logic [31:0] d;
    d = $urandom();
    if (P_DW[i] < 32) d = d & ((32'h1 << P_DW[i]) - 32'h1);
    return d;
  endfunction

  function automatic int cs_low_exp(input int i);
    return (2 * P_DW[i] + 2) * P_HALF[i];
  endfunction

  // Issues one request and records what the SPI pins did until cs_n rises.
  task automatic run_frame(input int i, input logic [31:0] data, input bit hold,
                           input int mid_pulse_at, output frame_t r);
    logic prev, cpol, samp_lvl;
    int   lim;
    r = '{default: 0};
    r.timeout = 1'b1;
    cpol     = (P_CPOL[i] != 0);
    samp_lvl = (P_CPHA[i] == 0) ? ~cpol : cpol;
    @(negedge clk);
    txd[i] = data;
    req[i] = 1'b1;
    @(negedge clk);
    if (!hold) req[i] = 1'b0;
    txd[i] = ~data;
    r.accept_ok  = (cs_n[i] === 1'b0) && (busy[i] === 1'b1);
    r.first_mosi = mosi[i];
    if (P_CPHA[i] != 0 && mosi[i] !== 1'b0) r.pre_mosi_bad = 1'b1;
    r.cs_low = 1;
    prev = sclk[i];
    lim = (2 * P_DW[i] + 4) * P_HALF[i] + 20;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (mid_pulse_at != 0) req[i] = (r.cs_low == mid_pulse_at);
      if (done[i] === 1'b1) r.n_done++;
      if (rxv[i] === 1'b1 && done[i] !== 1'b1) r.rxv_stray++;
      if (cs_n[i] === 1'b1) begin
        r.timeout      = 1'b0;
        r.done_at_rise = (done[i] === 1'b1);
        r.rxv_at_rise  = rxv[i];
        r.rx           = get_rx(i);
        r.mosi_end     = mosi[i];
        r.sclk_end     = sclk[i];
        break;
      end
      r.cs_low++;
      if (sclk[i] !== prev) begin
        r.edges++;
        prev = sclk[i];
        if (sclk[i] === samp_lvl && r.nbits < 32) begin
          r.bits[r.nbits] = mosi[i];
          r.nbits++;
        end
      end else if (P_CPHA[i] != 0 && r.edges == 0 && mosi[i] !== 1'b0) begin
        r.pre_mosi_bad = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 4 * P_HALF[i] + 10; c++) begin
      @(negedge clk);
      if (busy[i] === 1'b0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL idle_wait[%0d]: busy still %b, required 0", i, busy[i]); end
  endtask

  task automatic test_reset();
    logic [5:0] got, exp;
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < 4; i++) txd[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      got = {cs_n[i], sclk[i], mosi[i], busy[i], done[i], rxv[i]};
      exp = {1'b1, (P_CPOL[i] != 0), 4'b0000};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_pins[%0d]: got %b, required %b", i, got, exp); end
      n_checks++;
      if (get_rx(i) !== 32'h0) begin n_fail++; $display("FAIL reset_rx[%0d]: got %0h, required 0", i, get_rx(i)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_default();
    frame_t r;
    run_frame(0, 32'hA5, 1'b0, 0, r);
    n_checks++;
    if (!r.accept_ok || r.first_mosi !== 1'b1) begin
      n_fail++; $display("FAIL m0_accept: accept %b first_mosi %b, required 1 1", r.accept_ok, r.first_mosi);
    end
    n_checks++;
    if (r.nbits != 8 || r.bits !== 32'hA5) begin
      n_fail++; $display("FAIL m0_bits: got %0d bits %0h, required 8 bits a5", r.nbits, r.bits);
    end
    n_checks++;
    if (r.timeout || r.edges != 16 || r.cs_low != 450) begin
      n_fail++; $display("FAIL m0_timing: edges %0d cs_low %0d, required 16 450", r.edges, r.cs_low);
    end
    n_checks++;
    if (r.n_done != 1 || !r.done_at_rise || r.mosi_end !== 1'b0 || r.sclk_end !== 1'b0) begin
      n_fail++; $display("FAIL m0_end: done %0d at_rise %b mosi %b sclk %b, required 1 1 0 0",
                         r.n_done, r.done_at_rise, r.mosi_end, r.sclk_end);
    end
    wait_idle(0);
  endtask

  task automatic test_mode3_lsb();
    frame_t r;
    n_checks++;
    if (sclk[1] !== 1'b1) begin n_fail++; $display("FAIL m3_idle_sclk: got %b, required 1", sclk[1]); end
    run_frame(1, 32'h3C, 1'b0, 0, r);
    n_checks++;
    if (r.nbits != 8 || r.bits !== 32'h3C || r.bits !== model_bits(1, 32'h3C)) begin
      n_fail++; $display("FAIL m3_bits: got %0d bits %0h, required 8 bits 3c", r.nbits, r.bits);
    end
    n_checks++;
    if (r.pre_mosi_bad) begin n_fail++; $display("FAIL m3_pre_mosi: mosi nonzero before first edge, required 0"); end
    n_checks++;
    if (r.timeout || r.edges != 16 || r.cs_low != cs_low_exp(1) || r.n_done != 1 || r.sclk_end !== 1'b1) begin
      n_fail++; $display("FAIL m3_timing: edges %0d cs_low %0d done %0d sclk %b, required 16 %0d 1 1",
                         r.edges, r.cs_low, r.n_done, r.sclk_end, cs_low_exp(1));
    end
    wait_idle(1);
  endtask

  task automatic test_wide_ignore_req();
    frame_t r;
    int nlow, ndone;
    run_frame(2, 32'hBEEF, 1'b0, 20, r);
    n_checks++;
    if (r.timeout || r.edges != 32 || r.n_done != 1) begin
      n_fail++; $display("FAIL w16_edges: edges %0d done %0d, required 32 1", r.edges, r.n_done);
    end
    n_checks++;
    if (r.nbits != 16 || r.bits !== model_bits(2, 32'hBEEF)) begin
      n_fail++; $display("FAIL w16_bits: got %0d bits %0h, required 16 bits %0h", r.nbits, r.bits, model_bits(2, 32'hBEEF));
    end
    nlow = 0;
    ndone = 0;
    for (int c = 0; c < 4 * P_HALF[2] + 10; c++) begin
      @(negedge clk);
      if (cs_n[2] === 1'b0) nlow++;
      if (done[2] === 1'b1) ndone++;
    end
    n_checks++;
    if (nlow != 0 || ndone != 0 || busy[2] !== 1'b0) begin
      n_fail++; $display("FAIL w16_no_second: cs_low %0d done %0d busy %b, required 0 0 0", nlow, ndone, busy[2]);
    end
  endtask

  task automatic test_back_to_back();
    frame_t r;
    int   hi, blow, edges2;
    bit   ok;
    logic prev;
    run_frame(0, rand_data(0), 1'b1, 0, r);
    n_checks++;
    if (r.timeout || r.edges != 16) begin n_fail++; $display("FAIL b2b_first: edges %0d, required 16", r.edges); end
    hi = 1;
    blow = 0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cs_n[0] === 1'b0) begin ok = 1'b1; break; end
      hi++;
      if (busy[0] === 1'b0) blow++;
    end
    req[0] = 1'b0;
    n_checks++;
    if (!ok || hi != P_HALF[0]) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d, required %0d", hi, P_HALF[0]); end
    n_checks++;
    if (blow != 1) begin n_fail++; $display("FAIL b2b_busy_low: got %0d, required 1", blow); end
    edges2 = 0;
    ok = 1'b0;
    prev = sclk[0];
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (cs_n[0] === 1'b1) begin ok = 1'b1; break; end
      if (sclk[0] !== prev) begin edges2++; prev = sclk[0]; end
    end
    n_checks++;
    if (!ok || edges2 != 16) begin n_fail++; $display("FAIL b2b_second: edges %0d, required 16", edges2); end
    wait_idle(0);
  endtask

  task automatic test_reset_mid_frame();
    frame_t r;
    int   edges, nlow, ndone;
    logic prev;
    logic [31:0] d;
    @(negedge clk);
    txd[0] = 32'hFF;
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    edges = 0;
    prev = sclk[0];
    for (int c = 0; c < 400 && edges < 7; c++) begin
      @(negedge clk);
      if (sclk[0] !== prev) begin edges++; prev = sclk[0]; end
    end
    n_checks++;
    if (edges != 7) begin n_fail++; $display("FAIL rst_reach_shift: edges %0d, required 7", edges); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cs_n[0], sclk[0], mosi[0], busy[0], done[0]} !== 5'b10000) begin
      n_fail++; $display("FAIL rst_abort: got %b, required 10000", {cs_n[0], sclk[0], mosi[0], busy[0], done[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    nlow = 0;
    ndone = 0;
    for (int c = 0; c < 3 * P_HALF[0]; c++) begin
      @(negedge clk);
      if (cs_n[0] === 1'b0) nlow++;
      if (done[0] === 1'b1) ndone++;
    end
    n_checks++;
    if (nlow != 0 || ndone != 0) begin n_fail++; $display("FAIL rst_quiet: cs_low %0d done %0d, required 0 0", nlow, ndone); end
    d = rand_data(0);
    run_frame(0, d, 1'b0, 0, r);
    n_checks++;
    if (r.timeout || r.nbits != 8 || r.bits !== model_bits(0, d) || r.edges != 16 || r.n_done != 1) begin
      n_fail++; $display("FAIL rst_next_frame: bits %0h edges %0d done %0d, required %0h 16 1",
                         r.bits, r.edges, r.n_done, model_bits(0, d));
    end
    wait_idle(0);
  endtask

  task automatic test_random();
    frame_t r;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        d = rand_data(i);
        run_frame(i, d, 1'b0, 0, r);
        n_checks++;
        if (r.nbits != P_DW[i] || r.bits !== model_bits(i, d)) begin
          n_fail++; $display("FAIL rnd_bits[%0d] data %0h: got %0d bits %0h, required %0d bits %0h",
                             i, d, r.nbits, r.bits, P_DW[i], model_bits(i, d));
        end
        n_checks++;
        if (r.timeout || r.edges != 2 * P_DW[i] || r.cs_low != cs_low_exp(i)) begin
          n_fail++; $display("FAIL rnd_timing[%0d]: edges %0d cs_low %0d, required %0d %0d",
                             i, r.edges, r.cs_low, 2 * P_DW[i], cs_low_exp(i));
        end
        n_checks++;
        if (r.n_done != 1 || !r.done_at_rise || r.sclk_end !== (P_CPOL[i] != 0) || r.mosi_end !== 1'b0) begin
          n_fail++; $display("FAIL rnd_end[%0d]: done %0d at_rise %b sclk %b mosi %b",
                             i, r.n_done, r.done_at_rise, r.sclk_end, r.mosi_end);
        end
        n_checks++;
        if (r.rx !== (RX_EN ? d : 32'h0) || r.rxv_at_rise !== RX_EN || r.rxv_stray != 0) begin
          n_fail++; $display("FAIL rnd_rx[%0d]: got %0h valid %b stray %0d, required %0h valid %b",
                             i, r.rx, r.rxv_at_rise, r.rxv_stray, RX_EN ? d : 32'h0, RX_EN);
        end
        wait_idle(i);
      end
    end
  endtask

  task automatic test_rx_loopback();
    frame_t r;
    for (int i = 0; i < 4; i++) begin
      run_frame(i, 32'h5A, 1'b0, 0, r);
      n_checks++;
      if (r.rx !== (RX_EN ? 32'h5A : 32'h0) || r.rxv_at_rise !== RX_EN || r.rxv_stray != 0) begin
        n_fail++; $display("FAIL rx_5a[%0d]: got %0h valid %b stray %0d, required %0h valid %b",
                           i, r.rx, r.rxv_at_rise, r.rxv_stray, RX_EN ? 32'h5A : 32'h0, RX_EN);
      end
      wait_idle(i);
      repeat (2) @(negedge clk);
      n_checks++;
      if (get_rx(i) !== (RX_EN ? 32'h5A : 32'h0) || rxv[i] !== 1'b0) begin
        n_fail++; $display("FAIL rx_hold[%0d]: got %0h valid %b, required %0h 0",
                           i, get_rx(i), rxv[i], RX_EN ? 32'h5A : 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_default();
    test_mode3_lsb();
    test_wide_ignore_req();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_rx_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
